// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the round-robin APB3 master.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  localparam int APB_AW     = 32;
  localparam int APB_DW     = 32;
  localparam int PSEL_SLOTS = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational masked round-robin grant: requesters above the last-granted
// index win first, otherwise the search wraps to the lowest requester.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   last_i,
  output logic            valid_o,
  output logic [IW-1:0]   idx_o
);

  logic [NREQ-1:0] hi_mask;
  logic [NREQ-1:0] masked;
  logic            found;

  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < NREQ; i++) begin
      hi_mask[i] = (i > int'(last_i));
    end
    masked  = req_i & hi_mask;
    valid_o = |req_i;
    idx_o   = '0;
    found   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && masked[i]) begin
        idx_o = IW'(i);
        found = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_i[i]) begin
        idx_o = IW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_rr_master.sv
// Shares one APB3 master port between NREQ single-transfer requesters,
// granting round-robin and completing with wait-state and timeout handling.
//
// state  | meaning
// IDLE   | arbitrate over REQ & ~DONE; DONE pulse of previous transfer is here
// SETUP  | PSEL asserted for the latched slot, PENABLE low
// ACCESS | PENABLE high; wait for PREADY or wait-counter timeout
module apb_rr_master
  import apb_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int TIMEOUT  = 255,
  parameter int SLOT_LSB = 24
) (
  input  logic                   PCLK,
  input  logic                   PRESETN,
  input  logic [NREQ-1:0]        REQ,
  input  logic [NREQ-1:0]        REQ_WRITE,
  input  logic [NREQ*APB_AW-1:0] REQ_ADDR,
  input  logic [NREQ*APB_DW-1:0] REQ_WDATA,
  output logic [NREQ-1:0]        DONE,
  output logic [APB_DW-1:0]      RSP_RDATA,
  output logic                   RSP_ERR,
  output logic                   BUSY,
  output logic [APB_AW-1:0]      PADDR,
  output logic [PSEL_SLOTS-1:0]  PSEL,
  output logic                   PENABLE,
  output logic                   PWRITE,
  output logic [APB_DW-1:0]      PWDATA,
  input  logic [APB_DW-1:0]      PRDATA,
  input  logic                   PREADY,
  input  logic                   PSLVERR
);

  localparam int IW = $clog2(NREQ);
  // A disabled timeout still needs a 1-bit counter to keep widths legal.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_e              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [IW-1:0]       last_q, last_d;
  logic [APB_AW-1:0]   addr_q, addr_d;
  logic                write_q, write_d;
  logic [APB_DW-1:0]   wdata_q, wdata_d;
  logic [CW-1:0]       wait_q, wait_d;
  logic [NREQ-1:0]     done_q, done_d;
  logic [APB_DW-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  logic                arb_valid;
  logic [IW-1:0]       arb_idx;
  logic [3:0]          slot;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req_i   (REQ & ~done_q),
    .last_i  (last_q),
    .valid_o (arb_valid),
    .idx_o   (arb_idx)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    wait_d  = wait_q;
    done_d  = '0;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          idx_d   = arb_idx;
          last_d  = arb_idx;
          addr_d  = REQ_ADDR[int'(arb_idx)*APB_AW +: APB_AW];
          write_d = REQ_WRITE[arb_idx];
          wdata_d = REQ_WDATA[int'(arb_idx)*APB_DW +: APB_DW];
          state_d = SETUP;
        end
      end
      SETUP: begin
        wait_d  = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          rdata_d        = PRDATA;
          err_d          = PSLVERR;
          done_d[idx_q]  = 1'b1;
          state_d        = IDLE;
        end else if ((TIMEOUT != 0) && (wait_q == CW'(TIMEOUT))) begin
          rdata_d        = '0;
          err_d          = 1'b1;
          done_d[idx_q]  = 1'b1;
          state_d        = IDLE;
        end else if (wait_q != {CW{1'b1}}) begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q <= IDLE;
      idx_q   <= '0;
      last_q  <= IW'(NREQ - 1);
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      wait_q  <= '0;
      done_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      wait_q  <= wait_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // PSEL/PENABLE decode straight from the state register so reset drops them at once.
  assign slot      = addr_q[SLOT_LSB +: 4];
  assign PSEL      = (state_q != IDLE) ? (PSEL_SLOTS'(1) << slot) : '0;
  assign PENABLE   = (state_q == ACCESS);
  assign PADDR     = addr_q;
  assign PWRITE    = write_q;
  assign PWDATA    = wdata_q;
  assign DONE      = done_q;
  assign RSP_RDATA = rdata_q;
  assign RSP_ERR   = err_q;
  assign BUSY      = (state_q != IDLE);

endmodule

// File: tb/tb_apb_rr_master.sv
// Self-checking bench for apb_rr_master: vector table plus hand-written corner sequences.
module tb_apb_rr_master;

  logic         PCLK, PRESETN;
  logic [3:0]   REQ, REQ_WRITE;
  logic [127:0] REQ_ADDR, REQ_WDATA;
  logic [3:0]   DONE;
  logic [31:0]  RSP_RDATA, PADDR, PWDATA, PRDATA;
  logic         RSP_ERR, BUSY, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [15:0]  PSEL;

  logic [3:0]   r0_req;
  logic [3:0]   d0_done;
  logic [31:0]  d0_rdata, d0_paddr, d0_pwdata;
  logic         d0_err, d0_busy, d0_penable, d0_pwrite;
  logic [15:0]  d0_psel;

  apb_rr_master #(.NREQ(4), .TIMEOUT(4), .SLOT_LSB(24)) u_dut (
    .PCLK(PCLK), .PRESETN(PRESETN), .REQ(REQ), .REQ_WRITE(REQ_WRITE),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .DONE(DONE),
    .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR), .BUSY(BUSY), .PADDR(PADDR),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  apb_rr_master #(.NREQ(4), .TIMEOUT(0), .SLOT_LSB(24)) u_dut0 (
    .PCLK(PCLK), .PRESETN(PRESETN), .REQ(r0_req), .REQ_WRITE(4'b0),
    .REQ_ADDR(128'h0), .REQ_WDATA(128'h0), .DONE(d0_done),
    .RSP_RDATA(d0_rdata), .RSP_ERR(d0_err), .BUSY(d0_busy), .PADDR(d0_paddr),
    .PSEL(d0_psel), .PENABLE(d0_penable), .PWRITE(d0_pwrite), .PWDATA(d0_pwdata),
    .PRDATA(32'hFFFF_FFFF), .PREADY(1'b0), .PSLVERR(1'b0)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          idx;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } sb_t;
  sb_t sb[$];

  // Slave model: waits slv_waits ACCESS cycles, or never answers when slv_hang.
  int          slv_waits = 0;
  bit          slv_hang  = 0;
  logic [31:0] slv_rdata = 0;
  logic        slv_err   = 0;
  int          wcnt      = 0;

  initial begin
    PREADY = 0; PSLVERR = 0; PRDATA = 0;
    forever begin
      @(negedge PCLK);
      PRDATA = slv_rdata;
      if (PSEL != 0 && PENABLE) begin
        if (slv_hang || wcnt < slv_waits) begin
          PREADY = 0; PSLVERR = 0; wcnt++;
        end else begin
          PREADY = 1; PSLVERR = slv_err;
        end
      end else begin
        PREADY = 0; PSLVERR = 0; wcnt = 0;
      end
    end
  end

  // Scoreboard monitor: checks each SETUP against the head entry and pops on DONE.
  initial begin
    sb_t e;
    logic [3:0]  exp_done;
    logic [15:0] exp_psel;
    forever begin
      @(negedge PCLK);
      if (PRESETN) begin
        if (PSEL != 0 && !PENABLE) begin
          if (sb.size() == 0) chk("setup_unexpected", 1, 0);
          else begin
            e = sb[0];
            exp_psel = 16'h0001 << e.addr[27:24];
            chk("sb_psel", PSEL, exp_psel);
            chk("sb_paddr", PADDR, e.addr);
            chk("sb_pwrite", PWRITE, e.wr);
            chk("sb_pwdata", PWDATA, e.wdata);
          end
        end
        if (DONE != 0) begin
          if (sb.size() == 0) chk("done_unexpected", DONE, 0);
          else begin
            e = sb.pop_front();
            exp_done = 4'b0001 << e.idx;
            chk("sb_done_vec", DONE, exp_done);
            chk("sb_rdata", RSP_RDATA, e.rdata);
            chk("sb_err", RSP_ERR, e.err);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_cmd(input int i, input bit wr, input logic [31:0] a, input logic [31:0] wd);
    REQ_WRITE[i]          = wr;
    REQ_ADDR[i*32 +: 32]  = a;
    REQ_WDATA[i*32 +: 32] = wd;
  endtask

  task automatic do_reset();
    PRESETN = 0;
    REQ = 0;
    r0_req = 0;
    repeat (3) @(negedge PCLK);
    sb.delete();
    PRESETN = 1;
    @(negedge PCLK);
  endtask

  task automatic issue(input int i, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                       input int waits, input logic [31:0] rd, input bit er,
                       output int lat, output logic [15:0] psel_seen);
    slv_waits = waits; slv_rdata = rd; slv_err = er; slv_hang = 0;
    set_cmd(i, wr, a, wd);
    REQ[i] = 1;
    sb.push_back('{i, a, wr, wd, rd, er});
    lat = -1; psel_seen = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge PCLK);
      if (c == 1) psel_seen = PSEL;
      if (DONE[i]) begin
        lat = c;
        break;
      end
    end
    REQ[i] = 0;
    chk("issue_done_seen", lat > 0, 1);
  endtask

  typedef struct {
    int          idx;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] rdata;
    bit          err;
    logic [15:0] psel;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int          lat, acc, nd, total, last_done;
    int          cnt[4];
    logic [15:0] ps;

    vecs[0] = '{0, 1, 32'h0000_0100, 32'h1111_2222, 0, 32'hAAAA_0000, 0, 16'h0001};
    vecs[1] = '{1, 0, 32'h0500_0020, 32'h0,         1, 32'h5555_6666, 0, 16'h0020};
    vecs[2] = '{3, 1, 32'h0A00_0030, 32'hCAFE_F00D, 2, 32'h0000_0000, 1, 16'h0400};
    vecs[3] = '{2, 0, 32'h0700_0040, 32'h0,         4, 32'h7777_8888, 0, 16'h0080};
    vecs[4] = '{1, 1, 32'h0F00_FFFC, 32'hFFFF_FFFF, 0, 32'h0102_0304, 1, 16'h8000};
    vecs[5] = '{0, 0, 32'h0100_0000, 32'h0,         3, 32'h8000_0001, 0, 16'h0002};

    PRESETN = 0; REQ = 0; REQ_WRITE = 0; REQ_ADDR = 0; REQ_WDATA = 0; r0_req = 0;
    repeat (2) @(negedge PCLK);
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_pwrite", PWRITE, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwdata", PWDATA, 0);
    chk("rst_done", DONE, 0);
    chk("rst_rdata", RSP_RDATA, 0);
    chk("rst_err", RSP_ERR, 0);
    chk("rst_busy", BUSY, 0);
    PRESETN = 1;
    @(negedge PCLK);

    // Single zero-wait write from requester 2.
    slv_waits = 0; slv_rdata = 32'h0BAD_0000; slv_err = 0; slv_hang = 0;
    set_cmd(2, 1, 32'h0300_0010, 32'hA5A5_0001);
    REQ[2] = 1;
    sb.push_back('{2, 32'h0300_0010, 1'b1, 32'hA5A5_0001, 32'h0BAD_0000, 1'b0});
    @(negedge PCLK);
    chk("wr_c1_psel", PSEL, 16'h0008);
    chk("wr_c1_penable", PENABLE, 0);
    chk("wr_c1_busy", BUSY, 1);
    chk("wr_c1_pwdata", PWDATA, 32'hA5A5_0001);
    @(negedge PCLK);
    chk("wr_c2_psel", PSEL, 16'h0008);
    chk("wr_c2_penable", PENABLE, 1);
    @(negedge PCLK);
    chk("wr_c3_done", DONE, 4'b0100);
    chk("wr_c3_err", RSP_ERR, 0);
    chk("wr_c3_psel", PSEL, 0);
    REQ[2] = 0;
    @(negedge PCLK);
    chk("wr_c4_done_pulse", DONE, 0);

    // Read with three wait states and slave error.
    issue(0, 0, 32'h0F00_0004, 32'h0, 3, 32'h1234_5678, 1, lat, ps);
    chk("rdw_psel", ps, 16'h8000);
    chk("rdw_latency", lat, 6);
    chk("rdw_rdata", RSP_RDATA, 32'h1234_5678);
    chk("rdw_err", RSP_ERR, 1);
    @(negedge PCLK);

    foreach (vecs[k]) begin
      issue(vecs[k].idx, vecs[k].wr, vecs[k].addr, vecs[k].wdata,
            vecs[k].waits, vecs[k].rdata, vecs[k].err, lat, ps);
      chk($sformatf("vec%0d_psel", k), ps, vecs[k].psel);
      chk($sformatf("vec%0d_latency", k), lat, 3 + vecs[k].waits);
      @(negedge PCLK);
    end

    // Fairness: all four hold REQ for two transfers each.
    do_reset();
    slv_waits = 0; slv_rdata = 32'h600D_0000; slv_err = 0; slv_hang = 0;
    for (int i = 0; i < 4; i++) begin
      set_cmd(i, i[0], {4'h0, 4'(i + 4), 24'h000100 + 24'(i)}, 32'hF000_0000 + i);
      cnt[i] = 0;
    end
    for (int t = 0; t < 8; t++) begin
      sb.push_back('{t % 4, {4'h0, 4'((t % 4) + 4), 24'h000100 + 24'(t % 4)},
                     1'((t % 4) & 1), 32'hF000_0000 + (t % 4), 32'h600D_0000, 1'b0});
    end
    REQ = 4'b1111;
    total = 0; last_done = -1;
    for (int c = 1; c <= 100 && total < 8; c++) begin
      @(negedge PCLK);
      if (DONE != 0) begin
        if (last_done >= 0) chk("fair_gap", c - last_done, 3);
        last_done = c;
        total++;
        for (int i = 0; i < 4; i++) begin
          if (DONE[i]) begin
            cnt[i]++;
            if (cnt[i] == 2) REQ[i] = 0;
          end
        end
      end
    end
    chk("fair_total", total, 8);
    chk("fair_sb_empty", sb.size(), 0);
    @(negedge PCLK);

    // DONE masking: requester 1 holds REQ through its DONE while 3 waits.
    set_cmd(1, 1, 32'h0200_0000, 32'h1111_0001);
    set_cmd(3, 0, 32'h0C00_0000, 32'h0);
    slv_rdata = 32'h3333_0000;
    sb.push_back('{1, 32'h0200_0000, 1'b1, 32'h1111_0001, 32'h3333_0000, 1'b0});
    REQ[1] = 1;
    nd = 0;
    for (int c = 0; c < 20 && !PENABLE; c++) @(negedge PCLK);
    chk("mask_reached_access", PENABLE, 1);
    REQ[3] = 1;
    sb.push_back('{3, 32'h0C00_0000, 1'b0, 32'h0, 32'h3333_0000, 1'b0});
    for (int c = 0; c < 20 && !DONE[1]; c++) @(negedge PCLK);
    chk("mask_done1", DONE, 4'b0010);
    @(negedge PCLK);
    REQ[1] = 0;
    chk("mask_next_psel", PSEL, 16'h1000);
    chk("mask_next_paddr", PADDR, 32'h0C00_0000);
    for (int c = 0; c < 20 && !DONE[3]; c++) @(negedge PCLK);
    chk("mask_done3", DONE, 4'b1000);
    REQ[3] = 0;
    @(negedge PCLK);

    // Requester 1 alone holds REQ during DONE, then drops: no re-grant.
    sb.push_back('{1, 32'h0200_0000, 1'b1, 32'h1111_0001, 32'h3333_0000, 1'b0});
    REQ[1] = 1;
    for (int c = 0; c < 20 && !DONE[1]; c++) @(negedge PCLK);
    chk("solo_done1", DONE, 4'b0010);
    @(negedge PCLK);
    REQ[1] = 0;
    chk("solo_no_regrant", BUSY, 0);
    repeat (3) @(negedge PCLK);
    chk("solo_still_idle", BUSY, 0);

    // Timeout (TIMEOUT = 4): slave never answers.
    slv_hang = 1; slv_rdata = 32'hDEAD_BEEF;
    set_cmd(0, 0, 32'h0400_0008, 32'h0);
    sb.push_back('{0, 32'h0400_0008, 1'b0, 32'h0, 32'h0, 1'b1});
    REQ[0] = 1;
    acc = 0; lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge PCLK);
      if (PENABLE) acc++;
      if (DONE[0]) begin
        lat = c;
        break;
      end
    end
    REQ[0] = 0;
    chk("to_access_cycles", acc, 5);
    chk("to_latency", lat, 7);
    chk("to_err", RSP_ERR, 1);
    chk("to_rdata", RSP_RDATA, 0);
    @(negedge PCLK);

    // Reset mid-ACCESS.
    set_cmd(2, 1, 32'h0600_0000, 32'h7777_7777);
    sb.push_back('{2, 32'h0600_0000, 1'b1, 32'h7777_7777, 32'h0, 1'b1});
    REQ[2] = 1;
    for (int c = 0; c < 20 && !PENABLE; c++) @(negedge PCLK);
    chk("rmid_in_access", PENABLE, 1);
    #2;
    PRESETN = 0;
    #1;
    chk("rmid_psel", PSEL, 0);
    chk("rmid_penable", PENABLE, 0);
    chk("rmid_busy", BUSY, 0);
    REQ = 0;
    sb.delete();
    repeat (2) @(negedge PCLK);
    PRESETN = 1;
    nd = 0;
    repeat (10) begin
      @(negedge PCLK);
      if (DONE != 0) nd++;
    end
    chk("rmid_no_done", nd, 0);
    chk("rmid_idle", BUSY, 0);

    // TIMEOUT = 0 instance: stays in ACCESS indefinitely.
    r0_req[0] = 1;
    acc = 0; nd = 0;
    repeat (1005) begin
      @(negedge PCLK);
      if (d0_penable) acc++;
      if (d0_done != 0) nd++;
    end
    chk("t0_still_access", d0_penable, 1);
    chk("t0_busy", d0_busy, 1);
    chk("t0_no_done", nd, 0);
    chk("t0_access_ge_1000", acc >= 1000, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
